// File: rtl/decrypt_iterative.sv
// decrypt_iterative: iterative AES inverse cipher, one round per clock.
// Ports:
//   clk, reset          - rising-edge clock, synchronous active-high reset
//   start               - begin decrypting Cipher (accepted only when idle)
//   Cipher[0:127]       - ciphertext block, byte 0 in bits [0:7]
//   keySchedule         - all nr+1 round keys, round key r at [128*r +: 128]
//   Message[0:127]      - registered plaintext, updated with each done
//   busy                - a block is in flight
//   done                - one-cycle pulse, Message newly valid
module decrypt_iterative #(
   parameter int unsigned nk = 4,
   parameter int unsigned nr = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [0:127]          Cipher,
   input  logic [0:128*(nr+1)-1] keySchedule,
   output logic [0:127]          Message,
   output logic                  busy,
   output logic                  done
);

   localparam logic [3:0] last_round = 4'(nr - 1);

   // nk only documents the key size; reject inconsistent builds at elaboration
   if (nr != nk + 6) begin : g_bad_cfg
      $error("decrypt_iterative: nr must equal nk+6");
   end

   localparam logic [7:0] inv_sbox [256] = '{
      8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
      8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
      8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
      8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
      8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
      8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
      8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
      8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
      8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
      8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
      8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
      8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
      8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
      8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
      8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
      8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
   };

   // GF(2^8) multiply by x, reduction polynomial 0x11b
   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] mul_9(input logic [7:0] x);
      return xtime(xtime(xtime(x))) ^ x;
   endfunction

   function automatic logic [7:0] mul_b(input logic [7:0] x);
      return xtime(xtime(xtime(x))) ^ xtime(x) ^ x;
   endfunction

   function automatic logic [7:0] mul_d(input logic [7:0] x);
      return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ x;
   endfunction

   function automatic logic [7:0] mul_e(input logic [7:0] x);
      return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ xtime(x);
   endfunction

   // byte index = 4*column + row; row r rotates right by r columns
   function automatic logic [0:127] inv_shift_rows(input logic [0:127] s);
      logic [0:127] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[8*(4*c+r) +: 8] = s[8*(4*((c-r+4)%4)+r) +: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [0:127] inv_sub_bytes(input logic [0:127] s);
      logic [0:127] o;
      o = '0;
      for (int i = 0; i < 16; i++) begin
         o[8*i +: 8] = inv_sbox[s[8*i +: 8]];
      end
      return o;
   endfunction

   function automatic logic [0:127] inv_mix_columns(input logic [0:127] s);
      logic [0:127] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[32*c    +: 8];
         a1 = s[32*c+8  +: 8];
         a2 = s[32*c+16 +: 8];
         a3 = s[32*c+24 +: 8];
         o[32*c    +: 8] = mul_e(a0) ^ mul_b(a1) ^ mul_d(a2) ^ mul_9(a3);
         o[32*c+8  +: 8] = mul_9(a0) ^ mul_e(a1) ^ mul_b(a2) ^ mul_d(a3);
         o[32*c+16 +: 8] = mul_d(a0) ^ mul_9(a1) ^ mul_e(a2) ^ mul_b(a3);
         o[32*c+24 +: 8] = mul_b(a0) ^ mul_d(a1) ^ mul_9(a2) ^ mul_e(a3);
      end
      return o;
   endfunction

   logic [0:127] state;
   logic [3:0]   round;
   logic [0:127] round_key_c;
   logic [0:127] last_c;
   logic [0:127] full_c;

   // round key select and one inverse round; last_c is the final-round result
   always_comb begin
      round_key_c = '0;
      for (int unsigned r = 0; r <= nr; r++) begin
         if (round == 4'(r)) round_key_c = keySchedule[128*r +: 128];
      end
      last_c = inv_sub_bytes(inv_shift_rows(state)) ^ round_key_c;
      full_c = inv_mix_columns(last_c);
   end

   // round sequencing: load with K[nr], count down, finish on K[0]
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= '0;
         round   <= '0;
         Message <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (busy) begin
            if (round == 4'd0) begin
               Message <= last_c;
               done    <= 1'b1;
               busy    <= 1'b0;
            end else begin
               state <= full_c;
               round <= round - 4'd1;
            end
         end else if (start) begin
            state <= Cipher ^ keySchedule[128*nr +: 128];
            round <= last_round;
            busy  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_decrypt_iterative.sv
// tb_decrypt_iterative: directed and round-trip checks of decrypt_iterative
// for nr=10 and nr=14 builds. Key schedules and round-trip ciphertexts come
// from a forward-AES model in this bench.
module tb_decrypt_iterative;

   logic            clk;
   logic            reset;
   logic            start10, start14;
   logic [0:127]    cipher;
   logic [0:1407]   ks10;
   logic [0:1919]   ks14;
   logic [0:127]    msg10, msg14;
   logic            busy10, done10, busy14, done14;

   logic            big;
   logic            cur_busy, cur_done;
   logic [0:127]    cur_msg;

   int              checks;
   int              errors;
   logic [7:0]      sbox [256];

   decrypt_iterative #(.nk(4), .nr(10)) u_dut10 (
      .clk(clk), .reset(reset), .start(start10), .Cipher(cipher),
      .keySchedule(ks10), .Message(msg10), .busy(busy10), .done(done10));

   decrypt_iterative #(.nk(8), .nr(14)) u_dut14 (
      .clk(clk), .reset(reset), .start(start14), .Cipher(cipher),
      .keySchedule(ks14), .Message(msg14), .busy(busy14), .done(done14));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      cur_busy = big ? busy14 : busy10;
      cur_done = big ? done14 : done10;
      cur_msg  = big ? msg14  : msg10;
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- forward AES reference model ----------------
   function automatic logic [7:0] xt(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = xt(a);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         end
         sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
   endfunction

   function automatic logic [0:1919] expand(input logic [0:255] key, input int nkv);
      logic [31:0]   w [60];
      logic [31:0]   t;
      logic [7:0]    rc;
      logic [0:1919] ks;
      rc = 8'h01;
      ks = '0;
      for (int i = 0; i < 4 * (nkv + 7); i++) begin
         if (i < nkv) begin
            w[i] = key[32*i +: 32];
         end else begin
            t = w[i-1];
            if (i % nkv == 0) begin
               t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
               rc = xt(rc);
            end else if (nkv > 6 && i % nkv == 4) begin
               t = sub_word(t);
            end
            w[i] = w[i-nkv] ^ t;
         end
         ks[32*i +: 32] = w[i];
      end
      return ks;
   endfunction

   function automatic logic [0:127] encrypt(input logic [0:127] pt, input logic [0:1919] ks, input int nrv);
      logic [0:127] s, o;
      logic [7:0]   a0, a1, a2, a3;
      s = pt ^ ks[0 +: 128];
      for (int r = 1; r <= nrv; r++) begin
         for (int i = 0; i < 16; i++) s[8*i +: 8] = sbox[s[8*i +: 8]];
         o = '0;
         for (int c = 0; c < 4; c++)
            for (int q = 0; q < 4; q++)
               o[8*(4*c+q) +: 8] = s[8*(4*((c+q)%4)+q) +: 8];
         s = o;
         if (r != nrv) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[32*c +: 8]; a1 = s[32*c+8 +: 8]; a2 = s[32*c+16 +: 8]; a3 = s[32*c+24 +: 8];
               o[32*c    +: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
               o[32*c+8  +: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
               o[32*c+16 +: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
               o[32*c+24 +: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
            s = o;
         end
         s = s ^ ks[128*r +: 128];
      end
      return s;
   endfunction

   // ---------------- stimulus helpers ----------------
   // One block on the selected DUT; optional ignored start at cycle junk_at.
   task automatic run_block(input logic [0:127] c, input int junk_at,
                            output logic [0:127] m, output int lat, output int busy_n);
      @(negedge clk);
      cipher = c;
      if (big) start14 = 1'b1; else start10 = 1'b1;
      @(negedge clk);
      start10 = 1'b0; start14 = 1'b0;
      cipher  = ~c;
      busy_n  = cur_busy ? 1 : 0;
      lat     = 0;
      m       = '0;
      while (lat < 40) begin
         @(negedge clk);
         lat++;
         start10 = 1'b0; start14 = 1'b0;
         if (cur_busy) busy_n++;
         if (cur_done) begin
            m = cur_msg;
            break;
         end
         if (lat == junk_at) begin
            cipher = '0;
            if (big) start14 = 1'b1; else start10 = 1'b1;
         end
      end
   endtask

   task automatic count_idle(input int n, output int dones, output int busies);
      dones = 0; busies = 0;
      repeat (n) begin
         @(negedge clk);
         if (cur_done) dones++;
         if (cur_busy) busies++;
      end
   endtask

   localparam logic [0:127] key_a = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [0:127] ct_a  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [0:127] pt_a  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [0:127] key_b = 128'h5468617473206D79204B756E67204675;
   localparam logic [0:127] ct_b  = 128'h29C3505F571420F6402299B31A02D73A;
   localparam logic [0:127] pt_b  = 128'h54776F204F6E65204E696E652054776F;
   localparam logic [0:255] key_c = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [0:127] ct_c  = 128'h8ea2b7ca516745bfeafc49904b496089;

   initial begin
      logic [0:1919] ksa, ksb, ksr;
      logic [0:127]  m, pt, ct, key;
      int            lat, busy_n, dones, busies, idx, t, last;

      checks = 0; errors = 0;
      reset = 1'b1; start10 = 1'b0; start14 = 1'b0; big = 1'b0;
      cipher = '0; ks10 = '0; ks14 = '0;
      build_sbox();
      ksa = expand({key_a, 128'h0}, 4);
      ksb = expand({key_b, 128'h0}, 4);

      // reset state
      repeat (2) @(negedge clk);
      check("rst_msg10", msg10, 128'h0);
      check("rst_busy10", 128'(busy10), 128'h0);
      check("rst_done10", 128'(done10), 128'h0);
      check("rst_msg14", msg14, 128'h0);
      reset = 1'b0;

      // FIPS-197 C.1
      ks10 = ksa[0 +: 1408];
      run_block(ct_a, -1, m, lat, busy_n);
      check("c1_msg", m, pt_a);
      check("c1_latency", 128'(lat), 128'd10);
      check("c1_busy_cycles", 128'(busy_n), 128'd10);
      @(negedge clk);
      check("c1_done_drop", 128'(done10), 128'h0);
      repeat (3) @(negedge clk);
      check("c1_msg_hold", msg10, pt_a);

      // second key, then back-to-back with alternating key/ciphertext
      ks10 = ksb[0 +: 1408];
      run_block(ct_b, -1, m, lat, busy_n);
      check("kb_msg", m, pt_b);
      @(negedge clk);
      cipher = ct_b; start10 = 1'b1;
      idx = 0; t = 0; last = 0;
      while (idx < 4 && t < 100) begin
         @(negedge clk);
         t++;
         if (done10) begin
            check($sformatf("b2b_msg%0d", idx), msg10, (idx % 2 == 0) ? pt_b : pt_a);
            if (idx == 0) check("b2b_first_lat", 128'(t), 128'd11);
            else check($sformatf("b2b_gap%0d", idx), 128'(t - last), 128'd11);
            last = t;
            idx++;
            cipher = (idx % 2 == 0) ? ct_b : ct_a;
            ks10   = (idx % 2 == 0) ? ksb[0 +: 1408] : ksa[0 +: 1408];
            if (idx == 4) start10 = 1'b0;
         end
      end
      start10 = 1'b0;
      check("b2b_count", 128'(idx), 128'd4);

      // 256-bit key, nr=14 build
      big  = 1'b1;
      ks14 = expand(key_c, 8);
      run_block(ct_c, -1, m, lat, busy_n);
      check("k256_msg", m, pt_a);
      check("k256_latency", 128'(lat), 128'd14);
      big = 1'b0;

      // start while busy is ignored
      ks10 = ksb[0 +: 1408];
      run_block(ct_b, 3, m, lat, busy_n);
      check("ign_msg", m, pt_b);
      check("ign_latency", 128'(lat), 128'd10);
      count_idle(20, dones, busies);
      check("ign_extra_done", 128'(dones), 128'h0);
      check("ign_msg_hold", msg10, pt_b);

      // reset in the middle of a block
      ks10 = ksa[0 +: 1408];
      @(negedge clk);
      cipher = ct_a; start10 = 1'b1;
      @(negedge clk);
      start10 = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_busy", 128'(busy10), 128'h0);
      check("abort_done", 128'(done10), 128'h0);
      check("abort_msg", msg10, 128'h0);
      count_idle(15, dones, busies);
      check("abort_no_done", 128'(dones), 128'h0);

      // reset and start together
      reset = 1'b1; start10 = 1'b1; cipher = ct_a;
      @(negedge clk);
      reset = 1'b0; start10 = 1'b0;
      check("rs_busy", 128'(busy10), 128'h0);
      count_idle(15, dones, busies);
      check("rs_no_done", 128'(dones), 128'h0);
      check("rs_no_busy", 128'(busies), 128'h0);

      // fresh block after abort
      run_block(ct_a, -1, m, lat, busy_n);
      check("post_abort_msg", m, pt_a);
      check("post_abort_latency", 128'(lat), 128'd10);

      // random round trip through the forward model
      for (int n = 0; n < 50; n++) begin
         key = {$urandom, $urandom, $urandom, $urandom};
         pt  = {$urandom, $urandom, $urandom, $urandom};
         ksr = expand({key, 128'h0}, 4);
         ct  = encrypt(pt, ksr, 10);
         ks10 = ksr[0 +: 1408];
         run_block(ct, -1, m, lat, busy_n);
         check($sformatf("rt%0d", n), m, pt);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/decrypt_iterative.md
Name: decrypt_iterative

Overview:
- Iterative AES inverse cipher (FIPS-197 §5.3) executing one decryption round per clock, paired with the iterative encrypt datapath.
- Takes a 128-bit ciphertext and the full precomputed key schedule from the key-expansion block, and returns the 128-bit plaintext after nr+1 clock edges.
- start/busy/done handshake lets a controller issue back-to-back blocks.

Parameters:
nk, 4, key length in 32-bit words (4/6/8); documentation only, not used by the datapath.
nr, 10, number of rounds (10/12/14); must equal nk+6.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request to decrypt the current Cipher; sampled only when busy=0.
Cipher  input  [0:127]  ciphertext block; byte 0 = bits [0:7]; column-major state as in FIPS-197.
keySchedule  input  [0:128*(nr+1)-1]  round keys; round key r = keySchedule[128*r +: 128]; round 0 at bits [0:127].
Message  output  [0:127]  recovered plaintext, registered.
busy  output  1  high while a block is in flight.
done  output  1  one-cycle pulse; Message is valid and newly updated.

Behaviour:
- Reset (reset=1 at a rising edge):
  - Message=0, busy=0, done=0, state register=0, round counter=0.
  - reset has priority over start and aborts any block in flight; no done is produced for the aborted block.
- State register: 128 bits. Round counter: 4 bits, wide enough for nr=14.
- Edge E0 (start=1 and busy=0):
  - state <= Cipher XOR K[nr]; counter <= nr-1; busy <= 1.
  - Cipher is captured here and may change afterwards.
- Edges E1..E(nr-1), full inverse round with key K[counter]:
  - state <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), K[counter])).
  - counter decrements by 1.
- Edge E(nr), final round with K[0]:
  - Message <= AddRoundKey(InvSubBytes(InvShiftRows(state)), K[0]).
  - done <= 1; busy <= 0.
- done is deasserted at the next edge.
- Latency: done and the new Message are visible nr cycles after the cycle in which start was sampled.
- Throughput: one block per nr+1 cycles. A start asserted while done=1 is accepted (busy=0 then), so blocks run back to back with no gap.
- start while busy=1 is ignored; the request is not queued.
- keySchedule must remain stable from E0 through E(nr). It is not latched.
- Message holds its value between completions and is unchanged while a new block is in flight.
- InvShiftRows: row r rotated right by r bytes.
- InvSubBytes: 256-entry combinational inverse S-box.
- InvMixColumns: GF(2^8) with polynomial 0x11b, matrix {0e,0b,0d,09}.
- No X propagation: all registers are reset. The combinational path is purely a function of the state and the selected key.

Test Plan:
1. AES-128 FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f expanded by key-expansion block; Cipher=69c4e0d86a7b0430d8cdb78070b4c55a, start pulse -> done pulses exactly 10 cycles later, Message=00112233445566778899aabbccddeeff; busy high for 10 cycles.
2. AES-128 key 5468617473206D79204B756E67204675, Cipher=29C3505F571420F6402299B31A02D73A -> Message=54776F204F6E65204E696E652054776F. Then start held high continuously with this ciphertext and the C.1 ciphertext alternated -> correct Message on every done, done every 11 cycles with no idle cycle.
3. nk=8, nr=14 build, key 000102…1e1f, Cipher=8ea2b7ca516745bfeafc49904b496089 -> Message=00112233445566778899aabbccddeeff, done 14 cycles after start.
4. Start ignored: while busy, pulse start with Cipher=0 -> result unchanged from the first block, and exactly one done pulse is produced.
5. Reset mid-operation: assert reset 4 cycles after start -> next cycle busy=0, done=0, Message=0, no done for the aborted block. A fresh start then decrypts C.1 correctly. reset and start high in the same cycle -> remains idle.
6. Round trip: 50 random key/plaintext pairs through the encrypt datapath, whose ciphertext output is fed to Cipher -> Message equals the original plaintext for every pair.
